// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle ARMv4 main control FSM:
//   - state encodings (12 states, 4-bit)
//   - ALUSrcB / ResultSrc mux encodings
//   - instruction class (Op) codes
//   - packed Moore control word carried from the output decoder to the top
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECR   = 4'd7,
      S_EXECI   = 4'd8,
      S_ALUWB   = 4'd9,
      S_BRANCH  = 4'd10,
      S_UNKNOWN = 4'd11
   } state_e;

   // ALUSrcB select
   localparam logic [1:0] SRCB_WDATA = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // ResultSrc select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // Instruction class, instruction bits [27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   // Moore control word, one entry per state
   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_op;
      logic [1:0] result_src;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage : mc_ctrl_pkg

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational Moore output table: current state -> control word.
// Any encoding that is not one of the 12 defined states yields an all-zero
// control word.
// Ports:
//   state_i  in  4       current FSM state encoding
//   ctrl_o   out CTRL_W  packed control word (layout: mc_ctrl_pkg::ctrl_t)
// -----------------------------------------------------------------------------
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0]        state_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t c;

   always_comb begin
      c = '0;
      case (state_e'(state_i))
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.adr_src    = 1'b0;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
            c.next_pc    = 1'b1;
         end
         S_DECODE: begin
            // PC+4 from FETCH plus another 4 gives the architectural PC+8
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
         end
         S_EXECR: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = SRCB_WDATA;
            c.alu_op     = 1'b1;
         end
         S_EXECI: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = SRCB_IMM;
            c.alu_op     = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_w      = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMADR: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = SRCB_IMM;
         end
         S_MEMRD: begin
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_RDATA;
            c.reg_w      = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            c.adr_src    = 1'b1;
            c.mem_w      = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = SRCB_IMM;
            c.result_src = RES_ALURES;
            c.branch     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_UNKNOWN: begin
            c.illegal_op = 1'b1;
            c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
      ctrl_o = c;
   end

endmodule : mc_ctrl_decode

// File: rtl/mc_main_fsm.sv
// -----------------------------------------------------------------------------
// mc_main_fsm
// Main control state machine of the multicycle ARMv4 processor. Steps each
// instruction through fetch/decode/execute/memory/writeback and drives the
// datapath mux selects plus the raw NextPC/RegW/MemW/Branch strobes, which
// the downstream condition logic gates with CondEx.
//
// Optional feature macro: MC_MEM_WAIT_EN
//   defined   : mem_ready port exists; FETCH, MEMRD and MEMWR hold while
//               mem_ready=0. IRWrite/NextPC in FETCH and instr_done in MEMWR
//               fire only in the cycle mem_ready=1; MemW stays high while
//               MEMWR waits.
//   undefined : no mem_ready port, behaves as if mem_ready were tied to 1.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous reset, active low
//   Op         in   2        instruction bits [27:26]
//   Funct      in   6        instruction bits [25:20]; [5]=I, [0]=L/S
//   mem_ready  in   1        memory handshake (MC_MEM_WAIT_EN only)
//   IRWrite    out  1        load instruction register
//   AdrSrc     out  1        memory address: 0=PC, 1=ALUOut
//   ALUSrcA    out  1        0=register A, 1=PC
//   ALUSrcB    out  2        00=WriteData, 01=ExtImm, 10=constant 4
//   ALUOp      out  1        1=ALU decoder uses Funct, 0=ADD
//   ResultSrc  out  2        00=ALUOut, 01=ReadData, 10=ALUResult
//   NextPC     out  1        raw PC write strobe
//   RegW       out  1        raw register write strobe
//   MemW       out  1        raw memory write strobe
//   Branch     out  1        branch state, PC written if CondEx
//   instr_done out  1        pulse in the final state of each instruction
//   illegal_op out  1        pulse when Op==2'b11 is executed
//   state_dbg  out  STATE_W  current state encoding
// -----------------------------------------------------------------------------
module mc_main_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
`ifdef MC_MEM_WAIT_EN
   input  logic               mem_ready,
`endif
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               ALUOp,
   output logic [1:0]         ResultSrc,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg
);

   state_e              state_q;
   state_e              state_d;
   logic                rdy;
   logic                hold;
   logic [CTRL_W-1:0]   ctrl_vec;
   ctrl_t               ctrl;
   logic                unused_funct;

   // Only I (bit 5) and L/S (bit 0) steer the sequence; the rest goes to the
   // ALU decoder elsewhere.
   assign unused_funct = ^Funct[4:1];

`ifdef MC_MEM_WAIT_EN
   assign rdy = mem_ready;
`else
   assign rdy = 1'b1;
`endif

   // Cycles in which a memory-facing state is stalled on the handshake
   assign hold = ~rdy & ((state_q == S_FETCH) | (state_q == S_MEMWR));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:    state_d = S_FETCH;
         S_FETCH:   state_d = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_EXECR:   state_d = S_ALUWB;
         S_EXECI:   state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_MEMADR:  state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = rdy ? S_FETCH : S_MEMWR;
         S_BRANCH:  state_d = S_FETCH;
         S_UNKNOWN: state_d = S_FETCH;
         // Encodings 12..15 recover through IDLE
         default:   state_d = S_IDLE;
      endcase
   end

   mc_ctrl_decode u_decode (
      .state_i (state_q),
      .ctrl_o  (ctrl_vec)
   );

   assign ctrl = ctrl_t'(ctrl_vec);

   // Handshake-qualified strobes: fire only in the cycle the access completes
   assign IRWrite    = ctrl.ir_write   & ~hold;
   assign NextPC     = ctrl.next_pc    & ~hold;
   assign instr_done = ctrl.instr_done & ~hold;

   assign AdrSrc     = ctrl.adr_src;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUOp      = ctrl.alu_op;
   assign ResultSrc  = ctrl.result_src;
   assign RegW       = ctrl.reg_w;
   assign MemW       = ctrl.mem_w;
   assign Branch     = ctrl.branch;
   assign illegal_op = ctrl.illegal_op;
   assign state_dbg  = STATE_W'(state_q);

endmodule : mc_main_fsm
